// File: rtl/shift_buff_reg.sv
// Parameterised n-bit buffer / left-shift register with asynchronous clear.
// Each rising edge applies load, else shift-in of D_IN at the LSB, else hold.
module shift_buff_reg #(
  parameter int reg_size = 4
) (
  output logic [reg_size-1:0] Q,
  input  logic [reg_size-1:0] X,
  input  logic                LOAD,
  input  logic                SHIFT_L,
  input  logic                D_IN,
  input  logic                CLEAR,
  input  logic                CLOCK
);

  logic [reg_size-1:0] shifted;
  logic [reg_size-1:0] next_q;

  // A one-bit register has no upper bits to keep, so a shift is just D_IN.
  generate
    if (reg_size == 1) begin : g_single
      assign shifted = D_IN;
    end else begin : g_multi
      assign shifted = {Q[reg_size-2:0], D_IN};
    end
  endgenerate

  always_comb begin
    next_q = Q;
    if (LOAD)
      next_q = X;
    else if (SHIFT_L)
      next_q = shifted;
  end

  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR)
      Q <= '0;
    else
      Q <= next_q;
  end

endmodule

// File: tb/tb_shift_buff_reg.sv
// Self-checking bench for shift_buff_reg at widths 4, 8 and 1 sharing controls.
// Arithmetic model compared every cycle, plus hand-computed literal checks.
module tb_shift_buff_reg;

  logic       clock;
  logic       clear;
  logic       load;
  logic       shift;
  logic       din;
  logic [3:0] x4;
  logic [7:0] x8;
  logic       x1;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       q1;

  int  total;
  int  bad;
  bit  done;

  int  m4;
  int  m8;
  int  m1;
  bit  valid;

  assign x1 = x4[0];

  shift_buff_reg #(.reg_size(4)) dut4 (
    .Q(q4), .X(x4), .LOAD(load), .SHIFT_L(shift), .D_IN(din), .CLEAR(clear), .CLOCK(clock)
  );
  shift_buff_reg #(.reg_size(8)) dut8 (
    .Q(q8), .X(x8), .LOAD(load), .SHIFT_L(shift), .D_IN(din), .CLEAR(clear), .CLOCK(clock)
  );
  shift_buff_reg #(.reg_size(1)) dut1 (
    .Q(q1), .X(x1), .LOAD(load), .SHIFT_L(shift), .D_IN(din), .CLEAR(clear), .CLOCK(clock)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: a load copies X, a shift doubles the value, adds D_IN and wraps at 2^n.
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m4    <= 0;
      m8    <= 0;
      m1    <= 0;
      valid <= 1'b1;
    end else if (load) begin
      m4 <= int'(x4);
      m8 <= int'(x8);
      m1 <= int'(x1);
    end else if (shift) begin
      m4 <= (m4 * 2 + int'(din)) % 16;
      m8 <= (m8 * 2 + int'(din)) % 256;
      m1 <= int'(din);
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic s, input logic d,
                               input logic [3:0] a4, input logic [7:0] a8);
    load  = l;
    shift = s;
    din   = d;
    x4    = a4;
    x8    = a8;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] stream [13];
    logic [3:0] ser_a [4];
    logic [3:0] ser_a_q [4];
    logic [3:0] ser_b [4];
    logic [3:0] ser_b_q [4];
    total = 0;
    bad   = 0;
    done  = 1'b0;
    stream  = '{4'd4, 4'd10, 4'd5, 4'd3, 4'd1, 4'd8, 4'd9, 4'd4, 4'd2, 4'd0, 4'd8, 4'd4, 4'd6};
    ser_a   = '{4'd1, 4'd1, 4'd0, 4'd1};
    ser_a_q = '{4'hD, 4'hB, 4'h6, 4'hD};
    ser_b   = '{4'd1, 4'd0, 4'd0, 4'd0};
    ser_b_q = '{4'hB, 4'h6, 4'hC, 4'h8};

    clear = 1'b1;
    load  = 1'b0;
    shift = 1'b0;
    din   = 1'b0;
    x4    = 4'h0;
    x8    = 8'h00;

    fork
      begin
        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("reset_q4", {4'h0, q4}, 8'h00);
        checkOutput("reset_q8", q8, 8'h00);
        checkOutput("reset_q1", {7'h0, q1}, 8'h00);
        clear = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 4'hF, 8'hFF);
        checkOutput("preload", {4'h0, q4}, 8'h0F);

        // CLEAR raised mid-cycle must act before the next edge.
        #3;
        clear = 1'b1;
        #1;
        checkOutput("clear_async_q4", {4'h0, q4}, 8'h00);
        checkOutput("clear_async_q8", q8, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hA, 8'hAA);
        checkOutput("clear_hold1", {4'h0, q4}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hA, 8'hAA);
        checkOutput("clear_hold2", {4'h0, q4}, 8'h00);
        clear = 1'b0;
        #1;
        checkOutput("clear_release", {4'h0, q4}, 8'h00);

        foreach (stream[i]) begin
          applyStimulus(1'b1, 1'b0, 1'b1, stream[i], {stream[i], ~stream[i]});
          checkOutput($sformatf("load_%0d", i), {4'h0, q4}, {4'h0, stream[i]});
        end

        foreach (ser_a[i]) begin
          applyStimulus(1'b0, 1'b1, ser_a[i][0], 4'h3, 8'h33);
          checkOutput($sformatf("serA_%0d", i), {4'h0, q4}, {4'h0, ser_a_q[i]});
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        checkOutput("serA_hold", {4'h0, q4}, 8'h0D);

        foreach (ser_b[i]) begin
          applyStimulus(1'b0, 1'b1, ser_b[i][0], 4'h5, 8'h55);
          checkOutput($sformatf("serB_%0d", i), {4'h0, q4}, {4'h0, ser_b_q[i]});
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 4'hF, 8'hF0);
        checkOutput("hold_1", {4'h0, q4}, 8'h08);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h7, 8'h0F);
        checkOutput("hold_2", {4'h0, q4}, 8'h08);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h2, 8'h99);
        checkOutput("hold_3", {4'h0, q4}, 8'h08);

        applyStimulus(1'b1, 1'b1, 1'b1, 4'h3, 8'hA5);
        checkOutput("prio_q4", {4'h0, q4}, 8'h03);
        checkOutput("prio_q8", q8, 8'hA5);
        checkOutput("prio_q1", {7'h0, q1}, 8'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hC, 8'h00);
        checkOutput("shift8_after_load", q8, 8'h4A);
        checkOutput("shift4_after_load", {4'h0, q4}, 8'h06);
        checkOutput("shift1_after_load", {7'h0, q1}, 8'h00);

        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clock);
          if (valid) begin
            checkOutput("model_q4", {4'h0, q4}, 8'(m4));
            checkOutput("model_q8", q8, 8'(m8));
            checkOutput("model_q1", {7'h0, q1}, 8'(m1));
          end
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
